// File: rtl/ysyx_25040129_axi_sram_if.sv
// AXI4-style memory-side bus between an initiator and the on-chip SRAM responder.
// Single read and write channels; no IDs, one transaction in flight.
interface ysyx_25040129_axi_sram_if;
    logic [31:0] araddr;
    logic        arvalid;
    logic [2:0]  arsize;
    logic [7:0]  arlen;
    logic [1:0]  arburst;
    logic        arready;

    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;
    logic        rlast;

    logic [31:0] awaddr;
    logic        awvalid;
    logic        awready;

    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready;

    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;

    modport slave (
        input  araddr, arvalid, arsize, arlen, arburst,
        output arready,
        output rdata, rresp, rvalid, rlast,
        input  rready,
        input  awaddr, awvalid,
        output awready,
        input  wdata, wstrb, wvalid,
        output wready,
        output bresp, bvalid,
        input  bready
    );

    modport master (
        output araddr, arvalid, arsize, arlen, arburst,
        input  arready,
        input  rdata, rresp, rvalid, rlast,
        output rready,
        output awaddr, awvalid,
        input  awready,
        output wdata, wstrb, wvalid,
        input  wready,
        input  bresp, bvalid,
        output bready
    );
endinterface

// File: rtl/ysyx_25040129_axi_sram.sv
// Word-addressed on-chip SRAM answering AXI4-style bursts with fixed first-beat latency.
// Out-of-range or unsupported requests complete with SLVERR so initiators never hang.
module ysyx_25040129_axi_sram #(
    parameter logic [31:0] ADDR_BASE   = 32'h8000_0000,
    parameter int          DEPTH_WORDS = 1024,
    parameter int          READ_LAT    = 2,
    parameter int          WRITE_LAT   = 1
) (
    input  logic clk,
    input  logic rst,
    ysyx_25040129_axi_sram_if.slave bus
);
    localparam int          IDX_W = $clog2(DEPTH_WORDS);
    localparam logic [31:0] SPAN  = 32'(DEPTH_WORDS) * 32'd4;
    localparam logic [1:0]  OKAY  = 2'b00;
    localparam logic [1:0]  SLVERR = 2'b10;

    typedef enum logic [2:0] {
        IDLE,
        R_LAT,
        R_DATA,
        W_LAT,
        W_RESP
    } state_t;

    state_t state;
    state_t state_next;

    logic [31:0] mem [DEPTH_WORDS];

    logic        aw_held;
    logic        w_held;
    logic [31:0] aw_addr;
    logic [31:0] w_data;
    logic [3:0]  w_strb;
    logic        b_err;

    logic [31:0] ar_addr;
    logic [7:0]  ar_len;
    logic        ar_bad;
    logic        ar_fixed;
    logic [7:0]  beat;
    logic [15:0] cnt;

    logic aw_fire;
    logic w_fire;
    logic ar_fire;
    logic ar_ok;
    logic last_beat;

    logic [31:0]      rd_off;
    logic             rd_in_range;
    logic [IDX_W-1:0] rd_idx;
    logic             rd_err;
    logic [31:0]      wr_off;
    logic             wr_in_range;
    logic [IDX_W-1:0] wr_idx;
    logic             mem_we;
    logic             unused_bits;

    // Low two address bits are ignored; bits above the array span only matter for the range check.
    assign rd_off      = ar_addr - ADDR_BASE;
    assign rd_in_range = rd_off < SPAN;
    assign rd_idx      = rd_off[IDX_W+1:2];
    assign rd_err      = ar_bad || !rd_in_range;
    assign wr_off      = aw_addr - ADDR_BASE;
    assign wr_in_range = wr_off < SPAN;
    assign wr_idx      = wr_off[IDX_W+1:2];
    assign last_beat   = beat == ar_len;
    assign mem_we      = (state == W_LAT) && (cnt == 16'd0) && wr_in_range;
    assign unused_bits = ^{rd_off[1:0], rd_off[31:IDX_W+2], wr_off[1:0], wr_off[31:IDX_W+2]};

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next  = state;
        aw_fire     = 1'b0;
        w_fire      = 1'b0;
        ar_fire     = 1'b0;
        ar_ok       = 1'b0;
        bus.arready = 1'b0;
        bus.awready = 1'b0;
        bus.wready  = 1'b0;
        bus.rvalid  = 1'b0;
        bus.rlast   = 1'b0;
        bus.rdata   = '0;
        bus.rresp   = OKAY;
        bus.bvalid  = 1'b0;
        bus.bresp   = OKAY;
        unique case (state)
            IDLE: begin
                // Any write activity blocks AR so a simultaneous write is served first.
                ar_ok       = !aw_held && !w_held && !bus.awvalid && !bus.wvalid;
                bus.awready = !aw_held;
                bus.wready  = !w_held;
                bus.arready = ar_ok;
                aw_fire     = bus.awvalid && !aw_held;
                w_fire      = bus.wvalid && !w_held;
                ar_fire     = bus.arvalid && ar_ok;
                if ((aw_held || aw_fire) && (w_held || w_fire)) begin
                    state_next = W_LAT;
                end else if (ar_fire) begin
                    state_next = R_LAT;
                end
            end
            R_LAT: begin
                if (cnt == 16'd0) begin
                    state_next = R_DATA;
                end
            end
            R_DATA: begin
                bus.rvalid = 1'b1;
                bus.rlast  = last_beat;
                bus.rresp  = rd_err ? SLVERR : OKAY;
                bus.rdata  = rd_err ? 32'd0 : mem[rd_idx];
                if (bus.rready && last_beat) begin
                    state_next = IDLE;
                end
            end
            W_LAT: begin
                if (cnt == 16'd0) begin
                    state_next = W_RESP;
                end
            end
            W_RESP: begin
                bus.bvalid = 1'b1;
                bus.bresp  = b_err ? SLVERR : OKAY;
                if (bus.bready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            aw_held  <= 1'b0;
            w_held   <= 1'b0;
            aw_addr  <= '0;
            w_data   <= '0;
            w_strb   <= '0;
            b_err    <= 1'b0;
            ar_addr  <= '0;
            ar_len   <= '0;
            ar_bad   <= 1'b0;
            ar_fixed <= 1'b0;
            beat     <= '0;
            cnt      <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (aw_fire) begin
                        aw_held <= 1'b1;
                        aw_addr <= bus.awaddr;
                    end
                    if (w_fire) begin
                        w_held <= 1'b1;
                        w_data <= bus.wdata;
                        w_strb <= bus.wstrb;
                    end
                    if (state_next == W_LAT) begin
                        cnt <= 16'(WRITE_LAT - 1);
                    end else if (ar_fire) begin
                        ar_addr  <= bus.araddr;
                        ar_len   <= bus.arlen;
                        ar_bad   <= (bus.arsize > 3'd2) || bus.arburst[1];
                        ar_fixed <= bus.arburst == 2'b00;
                        beat     <= '0;
                        cnt      <= 16'(READ_LAT - 1);
                    end
                end
                R_LAT: begin
                    if (cnt != 16'd0) begin
                        cnt <= cnt - 16'd1;
                    end
                end
                R_DATA: begin
                    // Address wraps at 32 bits; beats past the array end report SLVERR.
                    if (bus.rready && !last_beat) begin
                        beat <= beat + 8'd1;
                        if (!ar_fixed) begin
                            ar_addr <= ar_addr + 32'd4;
                        end
                    end
                end
                W_LAT: begin
                    if (cnt != 16'd0) begin
                        cnt <= cnt - 16'd1;
                    end else begin
                        b_err   <= !wr_in_range;
                        aw_held <= 1'b0;
                        w_held  <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    // Array contents survive reset; a write still waiting in W_LAT is simply dropped.
    always_ff @(posedge clk) begin
        if (!rst && mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (w_strb[b]) begin
                    mem[wr_idx][8*b +: 8] <= w_data[8*b +: 8];
                end
            end
        end
    end
endmodule
